// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: APB-controlled 4-digit FND scanner.
// The block converts the written binary value to BCD one bit per cycle
// (double-dabble). It commits all four digits in a single cycle, so the
// display never shows a half-converted value. It then scans the digits
// onto fnd_com/fnd_data at a programmable rate.
// Optional feature: define FND_DP_EN to make FCR[7:4] a per-digit
// decimal-point mask. Without it, the decimal point stays dark.
module fnd_scan_ctrl #(
    parameter logic [15:0] SCAN_RST = 16'd49999,
    parameter logic [13:0] MAX_VAL  = 14'd9999
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic [4:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CONV   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

`ifdef FND_DP_EN
    localparam logic [7:0] FCR_MASK = 8'hF3;
`else
    localparam logic [7:0] FCR_MASK = 8'h03;
`endif

    logic        apb_access, wr_en, rd_en;
    logic        fcr_wr, fdr_wr, fpr_wr;
    logic [2:0]  reg_sel;
    logic        unused_bits;

    logic [7:0]  fcr_q, fcr_d;
    logic [13:0] fdr_q, fdr_d;
    logic [15:0] fpr_q, fpr_d;
    logic [15:0] bcd_q, bcd_d;
    logic        busy_q, busy_d, pend_q, pend_d, ovf_q, ovf_d;
    logic [1:0]  state_q, state_d;
    logic [29:0] shift_q, shift_d;
    logic [29:0] shift_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] scan_q, scan_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  com_q, com_d;
    logic [7:0]  data_q, data_d;

    assign apb_access  = PSEL & PENABLE;
    assign wr_en       = apb_access & PWRITE;
    assign rd_en       = apb_access & ~PWRITE;
    assign reg_sel     = PADDR[4:2];
    assign fcr_wr      = wr_en && (reg_sel == 3'd0);
    assign fdr_wr      = wr_en && (reg_sel == 3'd1);
    assign fpr_wr      = wr_en && (reg_sel == 3'd3);
    assign PREADY      = apb_access;
    assign fnd_com     = com_q;
    assign fnd_data    = data_q;
    assign unused_bits = ^{PWDATA[31:16], PADDR[1:0]};

    // Clamp an incoming value to the largest number the 4 digits can show
    function automatic logic [13:0] saturate(input logic [13:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // Segment pattern (g..a, active-low) of one decimal digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Register read mux; drives zero outside a read access phase
    always_comb begin
        PRDATA = 32'd0;
        if (rd_en) begin
            case (reg_sel)
                3'd0:    PRDATA = {24'd0, fcr_q};
                3'd1:    PRDATA = {18'd0, fdr_q};
                3'd2:    PRDATA = {29'd0, ovf_q, pend_q, busy_q};
                3'd3:    PRDATA = {16'd0, fpr_q};
                3'd4:    PRDATA = {16'd0, bcd_q};
                default: PRDATA = 32'd0;
            endcase
        end
    end

    // Add-3 correction on every BCD nibble that would overflow after shifting
    always_comb begin
        shift_adj = shift_q;
        for (int i = 0; i < 4; i++) begin
            if (shift_q[14 + 4*i +: 4] >= 4'd5) begin
                shift_adj[14 + 4*i +: 4] = shift_q[14 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Software registers plus the conversion sequencer (IDLE/CONV/COMMIT)
    always_comb begin
        fcr_d   = fcr_q;
        fdr_d   = fdr_q;
        fpr_d   = fpr_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        pend_d  = pend_q;
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (fcr_wr) fcr_d = PWDATA[7:0] & FCR_MASK;
        if (fpr_wr) fpr_d = PWDATA[15:0];
        if (fdr_wr) begin
            fdr_d = PWDATA[13:0];
            ovf_d = (PWDATA[13:0] > MAX_VAL);
        end
        case (state_q)
            ST_IDLE: begin
                if (fdr_wr) begin
                    shift_d = {16'd0, saturate(PWDATA[13:0])};
                    cnt_d   = 4'd0;
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                shift_d = {shift_adj[28:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = ST_COMMIT;
                if (fdr_wr) pend_d = 1'b1;
            end
            ST_COMMIT: begin
                bcd_d = shift_q[29:14];
                if (pend_q || fdr_wr) begin
                    pend_d  = 1'b0;
                    shift_d = {16'd0, saturate(fdr_wr ? PWDATA[13:0] : fdr_q)};
                    cnt_d   = 4'd0;
                    state_d = ST_CONV;
                end else begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scan timer: one digit per (FPR+1) cycles; an FPR write restarts the count
    always_comb begin
        scan_d = scan_q + 16'd1;
        sel_d  = sel_q;
        if (fpr_wr) begin
            scan_d = 16'd0;
        end else if (scan_q == fpr_q) begin
            scan_d = 16'd0;
            sel_d  = sel_q + 2'd1;
        end
    end

    // Next display drive for the selected digit, including leading-zero blanking
    always_comb begin
        logic [3:0] digit;
        logic       blank;
        logic       dp_n;
        logic [3:0] lead_zero;
        digit        = bcd_q[4*sel_q +: 4];
        lead_zero[3] = (bcd_q[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (bcd_q[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (bcd_q[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
        blank        = fcr_q[1] && lead_zero[sel_q];
`ifdef FND_DP_EN
        dp_n = ~fcr_q[3'd4 + {1'b0, sel_q}];
`else
        dp_n = 1'b1;
`endif
        com_d  = 4'hF;
        data_d = 8'hFF;
        if (fcr_q[0]) begin
            com_d  = ~(4'b0001 << sel_q);
            data_d = {dp_n, blank ? 7'h7F : seg7(digit)};
        end
    end

    // State update with synchronous active-low reset
    always_ff @(posedge PCLK) begin
        if (!PRESET) begin
            fcr_q   <= 8'd0;
            fdr_q   <= 14'd0;
            fpr_q   <= SCAN_RST;
            bcd_q   <= 16'd0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= ST_IDLE;
            shift_q <= 30'd0;
            cnt_q   <= 4'd0;
            scan_q  <= 16'd0;
            sel_q   <= 2'd0;
            com_q   <= 4'hF;
            data_q  <= 8'hFF;
        end else begin
            fcr_q   <= fcr_d;
            fdr_q   <= fdr_d;
            fpr_q   <= fpr_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            scan_q  <= scan_d;
            sel_q   <= sel_d;
            com_q   <= com_d;
            data_q  <= data_d;
        end
    end

endmodule
